instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage directly upstream of the control decoder.
- Owns the program counter and drives a synchronous-read instruction memory.
- Presents one 9-bit instruction per cycle, with a valid flag, to the decoder and datapath.
- Accepts a redirect (jump or taken branch) from execute and a stall from downstream; detects the program-end instruction and raises done.

Parameters:
- PC_W, 10, program counter / instruction address width (wraps at 2^PC_W).
- INSTR_W, 9, instruction width (matches decoder input).
- HALT_INSTR, 9'h1FE, encoding that terminates the program.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins fetching at address 0.
- stall  in  1  downstream not ready; hold the output instruction.
- redirect  in  1  jump/taken branch resolved for the instruction currently on instr.
- target  in  PC_W  absolute redirect address.
- imem_addr  out  PC_W  instruction memory read address.
- imem_rdata  in  INSTR_W  instruction memory data; valid one cycle after imem_addr.
- instr  out  INSTR_W  instruction to decoder.
- instr_pc  out  PC_W  address of instr.
- instr_valid  out  1  instr is live; downstream gates all writes with it.
- done  out  1  program finished; held until start or reset.

Behaviour:
- States: IDLE, RUN, DONE. Reset -> IDLE; reset wins over every other input in the same cycle, including mid-run.
- Internal registers:
  - fpc: address being issued.
  - req_pc / req_valid: address issued last cycle, and whether its data is wanted.
- Reset values: fpc=0, req_pc=0, req_valid=0, instr=0, instr_pc=0, instr_valid=0, done=0.
- imem_addr is combinational: req_pc when stall=1 and redirect=0; otherwise fpc.
- IDLE: start -> RUN; fpc<=1, req_pc<=0, req_valid<=1.
- DONE: same start action as IDLE, and done<=0. All other inputs are ignored in IDLE and DONE.
- RUN, normal cycle (stall=0, redirect=0):
  - instr<=imem_rdata, instr_pc<=req_pc, instr_valid<=req_valid.
  - req_pc<=fpc, req_valid<=1, fpc<=fpc+1 (mod 2^PC_W; 2^PC_W-1 wraps to 0).
- RUN, stall=1, redirect=0:
  - instr, instr_pc, instr_valid, fpc, req_pc and req_valid all hold.
  - Re-issuing req_pc keeps the data aligned when the stall releases.
- RUN, redirect=1 (priority over stall):
  - instr_valid<=0, req_valid<=0, fpc<=target.
  - Next cycle is a normal issue of target.
  - Fixed penalty: redirect in cycle N -> instr_valid=0 in N+1 and N+2; instr=mem[target], instr_valid=1 in N+3.
- Halt detection: if instr_valid=1, instr==HALT_INSTR and stall=0:
  - next state DONE, done<=1, instr_valid<=0, req_valid<=0, fpc holds.
  - A halt with redirect=1 in the same cycle takes the redirect instead (halt was on a squashed path).
- Latency: start in cycle S -> first instr_valid=1 (pc 0) in S+2; one instruction per cycle thereafter absent stall/redirect.
- instr_valid must never be 1 for an address fetched on a squashed path.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_cycles[31:0] (count of cycles in RUN) and perf_instrs[31:0] (count of instr_valid=1 && stall=0 cycles).
  - Both counters clear on reset and on start, and saturate at 32'hFFFFFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, start at cycle 2, memory holds i at address i -> instr_valid rises at cycle 4 with instr_pc=0, then instr_pc=1,2,3 on consecutive cycles, no gaps.
- stall high for 3 cycles while instr_pc=5 -> instr_pc/instr hold at 5 for those cycles; pc 6 appears the cycle after stall drops; no address skipped or duplicated.
- redirect with target=0x40 while instr_pc=7 -> two cycles of instr_valid=0, then instr_pc=0x40 valid; addresses 8 and 9 never appear valid.
- HALT_INSTR at address 3 -> done=1 the cycle after pc 3 is presented; instr_valid stays 0; a later start pulse clears done and restarts from pc 0.
- PC_W=4 run through address 15 -> next instr_pc=0; redirect and stall asserted together -> redirect taken; reset asserted mid-run -> all outputs zero the next cycle, state IDLE.
- With FETCH_PERF_EN: 10 RUN cycles including 2 stall cycles and 1 redirect -> perf_cycles=10, perf_instrs equals the count of unstalled valid cycles (checked against the bench model).

Source files
------------

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Fetch stage in front of the control decoder. Owns the program counter,
//   drives a synchronous-read instruction memory, and presents one
//   instruction per cycle with a valid flag. It handles redirects from
//   execute and stalls from downstream. When it presents the program-end
//   instruction, it raises done.
//
// Parameters
//   PC_W        program counter / instruction address width (wraps)
//   INSTR_W     instruction width
//   HALT_INSTR  encoding that terminates the program
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   start        in   one-cycle pulse, begins fetching at address 0
//   stall        in   downstream not ready, hold the presented instruction
//   redirect     in   jump/taken branch for the instruction on instr
//   target       in   absolute redirect address
//   imem_addr    out  instruction memory read address (combinational)
//   imem_rdata   in   instruction memory data, one cycle after imem_addr
//   instr        out  instruction to decoder
//   instr_pc     out  address of instr
//   instr_valid  out  instr is live
//   done         out  program finished, held until start or reset
//
// Optional feature (macro FETCH_PERF_EN)
//   perf_cycles  out  saturating count of cycles spent in RUN
//   perf_instrs  out  saturating count of instr_valid && !stall cycles
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int                   PC_W       = 10,
  parameter int                   INSTR_W    = 9,
  parameter logic [INSTR_W-1:0]   HALT_INSTR = 9'h1FE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  output logic               done
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_cycles,
  output logic [31:0]        perf_instrs
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [PC_W-1:0]    fpc;
  logic [PC_W-1:0]    fpc_next;
  logic [PC_W-1:0]    req_pc;
  logic [PC_W-1:0]    req_pc_next;
  logic               req_valid;
  logic               req_valid_next;
  logic [INSTR_W-1:0] instr_next;
  logic [PC_W-1:0]    instr_pc_next;
  logic               instr_valid_next;
  logic               done_next;
  logic               halt_hit;

  // Read address. Outside RUN, address 0 is always issued. A start pulse
  // then finds mem[0] on imem_rdata in the first RUN cycle, whatever fpc
  // was left holding by a previous halt. During a stall the outstanding
  // request is re-issued so the data still matches req_pc when the stall
  // releases.
  always_comb begin
    imem_addr = fpc;
    if (state != RUN) begin
      imem_addr = '0;
    end else if (stall && !redirect) begin
      imem_addr = req_pc;
    end else begin
      imem_addr = fpc;
    end
  end

  // A halt counts only when it is actually consumed, that is, when it is
  // valid and not stalled.
  assign halt_hit = instr_valid && (instr == HALT_INSTR) && !stall;

  // Next-state and next-register logic for the fetch FSM.
  always_comb begin
    state_next       = state;
    fpc_next         = fpc;
    req_pc_next      = req_pc;
    req_valid_next   = req_valid;
    instr_next       = instr;
    instr_pc_next    = instr_pc;
    instr_valid_next = instr_valid;
    done_next        = done;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          // Address 0 is being issued this cycle, so the next fetch is 1.
          state_next     = RUN;
          fpc_next       = PC_W'(1);
          req_pc_next    = '0;
          req_valid_next = 1'b1;
          done_next      = 1'b0;
        end else begin
          state_next = state;
        end
      end

      RUN: begin
        if (redirect) begin
          // Squash the presented slot and the in-flight request. The
          // target is issued on the next cycle, which gives a fixed
          // two-bubble penalty.
          instr_valid_next = 1'b0;
          req_valid_next   = 1'b0;
          fpc_next         = target;
        end else if (halt_hit) begin
          state_next       = DONE;
          done_next        = 1'b1;
          instr_valid_next = 1'b0;
          req_valid_next   = 1'b0;
        end else if (!stall) begin
          instr_next       = imem_rdata;
          instr_pc_next    = req_pc;
          instr_valid_next = req_valid;
          req_pc_next      = fpc;
          req_valid_next   = 1'b1;
          fpc_next         = fpc + PC_W'(1);
        end else begin
          // Stall: every register holds its value.
          state_next = RUN;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and pipeline registers. Reset takes priority over all other inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      fpc         <= '0;
      req_pc      <= '0;
      req_valid   <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      fpc         <= fpc_next;
      req_pc      <= req_pc_next;
      req_valid   <= req_valid_next;
      instr       <= instr_next;
      instr_pc    <= instr_pc_next;
      instr_valid <= instr_valid_next;
      done        <= done_next;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating performance counters. They clear when a start is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles <= 32'd0;
      perf_instrs <= 32'd0;
    end else if ((state != RUN) && start) begin
      perf_cycles <= 32'd0;
      perf_instrs <= 32'd0;
    end else begin
      if ((state == RUN) && (perf_cycles != 32'hFFFF_FFFF)) begin
        perf_cycles <= perf_cycles + 32'd1;
      end
      if (instr_valid && !stall && (perf_instrs != 32'hFFFF_FFFF)) begin
        perf_instrs <= perf_instrs + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Self-checking bench for instr_fetch. A behavioural model tracks the
//   expected stream of presented addresses. It uses a "next address" and a
//   "bubbles still owed" count, not the fetch pipeline registers. Directed
//   sequences are followed by a randomized phase. All comparisons go
//   through check_eq.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [8:0] HALT = 9'h1FE;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       redirect = 1'b0;
  logic [9:0] target = 10'd0;
  logic [9:0] imem_addr;
  logic [8:0] imem_rdata;
  logic [8:0] instr;
  logic [9:0] instr_pc;
  logic       instr_valid;
  logic       done;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_instrs;
`endif

  logic [8:0] mem [0:1023];

  int checks = 0;
  int failures = 0;

  // Behavioural model state.
  logic        m_run;
  logic        m_done;
  logic        m_valid;
  logic [9:0]  m_pc;
  logic [8:0]  m_instr;
  logic [9:0]  m_next;
  int          m_gap;
  logic        m_exact;
  logic [31:0] m_pcyc;
  logic [31:0] m_pins;

  instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .redirect    (redirect),
    .target      (target),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .done        (done)
`ifdef FETCH_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_instrs (perf_instrs)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic fill_linear();
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] a;
      a = 10'(i);
      mem[i] = (a[8:0] == HALT) ? 9'h055 : a[8:0];
    end
  endtask

  // Advance the model by one clock edge, using the inputs applied this cycle.
  task automatic model_update(input logic rs, st, sl, rd, input logic [9:0] tg);
    if (rs) begin
      m_run = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_pc = 10'd0;
      m_instr = 9'd0; m_next = 10'd0; m_gap = 0; m_exact = 1'b1;
      m_pcyc = 32'd0; m_pins = 32'd0;
    end else if (!m_run) begin
      if (st) begin
        m_run = 1'b1; m_done = 1'b0; m_next = 10'd0; m_gap = 0;
        m_exact = 1'b0; m_pcyc = 32'd0; m_pins = 32'd0;
      end
    end else begin
      m_pcyc = sat_inc(m_pcyc);
      if (m_valid && !sl) m_pins = sat_inc(m_pins);
      if (rd) begin
        m_valid = 1'b0; m_gap = 1; m_next = tg;
      end else if (m_valid && m_instr == HALT && !sl) begin
        m_valid = 1'b0; m_done = 1'b1; m_run = 1'b0;
      end else if (!sl) begin
        if (m_gap > 0) begin
          m_valid = 1'b0; m_gap--;
        end else begin
          m_valid = 1'b1; m_pc = m_next; m_instr = mem[m_next];
          m_next = m_next + 10'd1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check_eq("done", {31'd0, done}, {31'd0, m_done});
    check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    if (m_valid || m_exact) begin
      check_eq("instr_pc", {22'd0, instr_pc}, {22'd0, m_pc});
      check_eq("instr", {23'd0, instr}, {23'd0, m_instr});
    end
`ifdef FETCH_PERF_EN
    check_eq("perf_cycles", perf_cycles, m_pcyc);
    check_eq("perf_instrs", perf_instrs, m_pins);
`endif
  endtask

  // Called just after a negedge: apply inputs, step the model, move to the
  // next negedge and compare.
  task automatic step(input logic rs, st, sl, rd, input logic [9:0] tg);
    reset = rs; start = st; stall = sl; redirect = rd; target = tg;
    model_update(rs, st, sl, rd, tg);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run1();
    step(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
  endtask

  initial begin
    m_run = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_pc = 10'd0; m_instr = 9'd0;
    m_next = 10'd0; m_gap = 0; m_exact = 1'b1; m_pcyc = 32'd0; m_pins = 32'd0;
    fill_linear();
    @(negedge clk);

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 10'd0);   // reset beats start
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_pc", {22'd0, instr_pc}, 32'd0);

    // Start, then pc 0 two cycles later, followed by 1,2,3 without gaps.
    step(1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
    check_eq("lat_bubble", {31'd0, instr_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      run1();
      check_eq("seq_valid", {31'd0, instr_valid}, 32'd1);
      check_eq("seq_pc", {22'd0, instr_pc}, 32'(k));
    end

    // A three-cycle stall at pc 5 holds; pc 6 follows.
    run1(); run1();
    check_eq("pre_stall_pc", {22'd0, instr_pc}, 32'd5);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
      check_eq("stall_hold_pc", {22'd0, instr_pc}, 32'd5);
      check_eq("stall_hold_instr", {23'd0, instr}, 32'd5);
    end
    run1();
    check_eq("post_stall_pc", {22'd0, instr_pc}, 32'd6);

    // Redirect to 0x40 at pc 7: two bubbles, then 0x40.
    run1();
    check_eq("pre_redir_pc", {22'd0, instr_pc}, 32'd7);
    step(1'b0, 1'b0, 1'b0, 1'b1, 10'h040);
    check_eq("redir_b1", {31'd0, instr_valid}, 32'd0);
    run1();
    check_eq("redir_b2", {31'd0, instr_valid}, 32'd0);
    run1();
    check_eq("redir_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("redir_pc", {22'd0, instr_pc}, 32'h040);

    // Address wrap: 0x3FE, 0x3FF, 0x000.
    step(1'b0, 1'b0, 1'b0, 1'b1, 10'h3FE);
    run1(); run1();
    check_eq("wrap_3fe", {22'd0, instr_pc}, 32'h3FE);
    run1();
    check_eq("wrap_3ff", {22'd0, instr_pc}, 32'h3FF);
    run1();
    check_eq("wrap_000", {22'd0, instr_pc}, 32'h000);

    // Redirect and stall together: the redirect wins.
    step(1'b0, 1'b0, 1'b1, 1'b1, 10'h020);
    run1(); run1();
    check_eq("rs_pc", {22'd0, instr_pc}, 32'h020);

    // Reset mid-run zeroes everything; IDLE ignores stall and redirect.
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    check_eq("midrst_pc", {22'd0, instr_pc}, 32'd0);
    check_eq("midrst_instr", {23'd0, instr}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 10'h011);
    run1(); run1();
    check_eq("idle_quiet", {31'd0, instr_valid}, 32'd0);

    // Halt at address 3, then restart from pc 0.
    mem[3] = HALT;
    step(1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
    for (int k = 0; k < 4; k++) run1();
    check_eq("halt_pc3", {22'd0, instr_pc}, 32'd3);
    run1();
    check_eq("halt_done", {31'd0, done}, 32'd1);
    check_eq("halt_novalid", {31'd0, instr_valid}, 32'd0);
    run1(); run1();
    mem[3] = 9'd3;
    step(1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
    check_eq("restart_clr", {31'd0, done}, 32'd0);
    run1();
    check_eq("restart_pc0", {22'd0, instr_pc}, 32'd0);

`ifdef FETCH_PERF_EN
    // Ten RUN cycles with two stalls and one redirect.
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
    run1(); run1(); run1();
    step(1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
    run1();
    step(1'b0, 1'b0, 1'b0, 1'b1, 10'h100);
    run1(); run1(); run1();
    check_eq("perf_cycles10", perf_cycles, 32'd10);
`endif

    // Random phase: random program with a few planted halts.
    for (int i = 0; i < 1024; i++) begin
      logic [8:0] v;
      v = 9'($urandom);
      mem[i] = (v == HALT) ? 9'h000 : v;
    end
    for (int k = 0; k < 6; k++) mem[$urandom_range(0, 1023)] = HALT;
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 499) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0),
           10'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
